// File: rtl/ifu_fetch_queue_if.sv
// ifu_fetch_queue_if: memory fetch and instruction delivery channels of the fetch queue
//   master (fetch queue): drives mem_req_valid_o/mem_req_addr_o and inst_valid_o/addr/data/fault,
//                         samples mem_req_ready_i, mem_resp_* and inst_ready_i
//   slave  (environment): the mirror image of master
interface ifu_fetch_queue_if #(
   parameter int XLEN = 32
);
   logic            mem_req_valid_o;
   logic            mem_req_ready_i;
   logic [XLEN-1:0] mem_req_addr_o;
   logic            mem_resp_valid_i;
   logic [31:0]     mem_resp_data_i;
   logic            mem_resp_fault_i;
   logic            inst_valid_o;
   logic            inst_ready_i;
   logic [XLEN-1:0] inst_addr_o;
   logic [31:0]     inst_data_o;
   logic            inst_fault_o;
   modport master (
      output mem_req_valid_o, mem_req_addr_o, inst_valid_o, inst_addr_o, inst_data_o, inst_fault_o,
      input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i, mem_resp_fault_i, inst_ready_i
   );
   modport slave (
      input  mem_req_valid_o, mem_req_addr_o, inst_valid_o, inst_addr_o, inst_data_o, inst_fault_o,
      output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i, mem_resp_fault_i, inst_ready_i
   );
endinterface

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: in-order instruction fetch queue with redirect flush and fault hold
//   clk, rst_n        : clock, asynchronous active-low reset
//   fetch_en_i        : permits new fetch requests
//   redirect_valid_i  : flush queue and restart fetch at redirect_pc_i
//   bus (master)      : memory request/response channel and instruction output channel
//   queue_count_o     : allocated entries (issued plus filled)
//   busy_o            : outstanding requests or pending drops
//   Macro IFQ_BYPASS_EN: present a response targeting an unfilled head entry in the same cycle
module ifu_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h3000_0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     fetch_en_i,
   input  logic                     redirect_valid_i,
   input  logic [XLEN-1:0]          redirect_pc_i,
   ifu_fetch_queue_if.master        bus,
   output logic [$clog2(DEPTH):0]   queue_count_o,
   output logic                     busy_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {IDLE, RUN, FAULT_HOLD} state_t;
   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [PW-1:0]     alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
   logic [CW-1:0]     count_q, count_d, out_q, out_d, drop_q, drop_d;
   logic [XLEN-1:0]   addr_q [DEPTH], addr_d [DEPTH];
   logic [31:0]       data_q [DEPTH], data_d [DEPTH];
   logic              fault_q [DEPTH], fault_d [DEPTH];
   logic              filled_q [DEPTH], filled_d [DEPTH];
   logic              req_fire, fill_en, consume, byp, resp_any;
   logic [31:0]       resp_word;
   // A response is kept only when nothing is pending drop, it matches an issued entry,
   // and it does not coincide with a redirect (that one is dropped instead).
   assign fill_en   = bus.mem_resp_valid_i && drop_q == '0 && out_q != '0 && !redirect_valid_i;
   assign resp_word = bus.mem_resp_fault_i ? 32'h0000_0013 : bus.mem_resp_data_i;
   // resp_any: a response that will be consumed by either a fill or a drop
   assign resp_any  = bus.mem_resp_valid_i && (drop_q != '0 || out_q != '0);
`ifdef IFQ_BYPASS_EN
   assign byp = fill_en && fill_q == head_q && !filled_q[head_q];
`else
   assign byp = 1'b0;
`endif
   assign bus.mem_req_valid_o = state_q == RUN && count_q < CW'(DEPTH) && drop_q == '0 && !redirect_valid_i;
   assign bus.mem_req_addr_o  = {pc_q[XLEN-1:2], 2'b00};
   assign bus.inst_valid_o    = filled_q[head_q] || byp;
   assign bus.inst_addr_o     = addr_q[head_q];
   assign bus.inst_data_o     = byp ? resp_word : data_q[head_q];
   assign bus.inst_fault_o    = byp ? bus.mem_resp_fault_i : fault_q[head_q];
   assign req_fire            = bus.mem_req_valid_o && bus.mem_req_ready_i;
   assign consume             = bus.inst_valid_o && bus.inst_ready_i;
   assign queue_count_o       = count_q;
   assign busy_o              = out_q != '0 || drop_q != '0;
   always_comb begin
      state_d = redirect_valid_i ? (fetch_en_i ? RUN : IDLE)
              : state_q == IDLE  ? (fetch_en_i ? RUN : IDLE)
              : state_q == RUN   ? (!fetch_en_i ? IDLE : (fill_en && bus.mem_resp_fault_i) ? FAULT_HOLD : RUN)
              : state_q;
      pc_d    = redirect_valid_i ? redirect_pc_i : req_fire ? pc_q + XLEN'(4) : pc_q;
      alloc_d = redirect_valid_i ? '0 : alloc_q + PW'(req_fire);
      fill_d  = redirect_valid_i ? '0 : fill_q + PW'(fill_en);
      head_d  = redirect_valid_i ? '0 : head_q + PW'(consume);
      count_d = redirect_valid_i ? '0 : count_q + CW'(req_fire) - CW'(consume);
      out_d   = redirect_valid_i ? '0 : out_q + CW'(req_fire) - CW'(fill_en);
      // Redirect turns every issued-but-unfilled entry into a pending drop; a response
      // arriving in the same cycle retires one of them immediately.
      drop_d  = redirect_valid_i ? drop_q + out_q - CW'(resp_any)
                                 : drop_q - CW'(bus.mem_resp_valid_i && drop_q != '0);
      addr_d   = addr_q;
      data_d   = data_q;
      fault_d  = fault_q;
      filled_d = filled_q;
      if (req_fire) begin
         addr_d[alloc_q]   = bus.mem_req_addr_o;
         data_d[alloc_q]   = '0;
         fault_d[alloc_q]  = 1'b0;
         filled_d[alloc_q] = 1'b0;
      end
      if (fill_en) begin
         data_d[fill_q]   = resp_word;
         fault_d[fill_q]  = bus.mem_resp_fault_i;
         filled_d[fill_q] = 1'b1;
      end
      // Clearing after the fill leaves a bypassed-and-consumed entry unfilled.
      if (consume) begin
         addr_d[head_q]   = '0;
         data_d[head_q]   = '0;
         fault_d[head_q]  = 1'b0;
         filled_d[head_q] = 1'b0;
      end
      if (redirect_valid_i) begin
         addr_d   = '{default: '0};
         data_d   = '{default: '0};
         fault_d  = '{default: 1'b0};
         filled_d = '{default: 1'b0};
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         alloc_q  <= '0;
         fill_q   <= '0;
         head_q   <= '0;
         count_q  <= '0;
         out_q    <= '0;
         drop_q   <= '0;
         addr_q   <= '{default: '0};
         data_q   <= '{default: '0};
         fault_q  <= '{default: 1'b0};
         filled_q <= '{default: 1'b0};
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         alloc_q  <= alloc_d;
         fill_q   <= fill_d;
         head_q   <= head_d;
         count_q  <= count_d;
         out_q    <= out_d;
         drop_q   <= drop_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         fault_q  <= fault_d;
         filled_q <= filled_d;
      end
   end
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb_ifu_fetch_queue: directed self-checking bench for ifu_fetch_queue
module tb_ifu_fetch_queue;
   logic        clk;
   logic        rst_n;
   logic        fetch_en_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic [2:0]  queue_count_o;
   logic        busy_o;
   int          errors;
   int          checks;
   int          nfire;
   int          resp_cnt;
   int          fault_idx;
   bit          auto_resp;
   logic [31:0] pend [$];

   ifu_fetch_queue_if #(.XLEN(32)) bus ();

   ifu_fetch_queue dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fetch_en_i       (fetch_en_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .bus              (bus),
      .queue_count_o    (queue_count_o),
      .busy_o           (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] dat(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic give_resp();
      resp_cnt++;
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_resp_fault_i = (resp_cnt == fault_idx);
      bus.mem_resp_data_i  = (pend.size() > 0) ? dat(pend.pop_front()) : 32'h0;
   endtask

   task automatic tick();
      logic        f;
      logic [31:0] a;
      f = bus.mem_req_valid_o && bus.mem_req_ready_i;
      a = bus.mem_req_addr_o;
      @(posedge clk);
      #1;
      if (f) begin
         pend.push_back(a);
         nfire++;
      end
      if (auto_resp) begin
         if (pend.size() > 0) give_resp();
         else bus.mem_resp_valid_i = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      fetch_en_i = 1'b0;
      redirect_valid_i = 1'b0;
      redirect_pc_i = 32'h0;
      bus.mem_req_ready_i = 1'b0;
      bus.mem_resp_valid_i = 1'b0;
      bus.mem_resp_data_i = 32'h0;
      bus.mem_resp_fault_i = 1'b0;
      bus.inst_ready_i = 1'b0;
      pend.delete();
      nfire = 0;
      resp_cnt = 0;
      fault_idx = 0;
      auto_resp = 1'b0;
      #1;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2;
      do_reset();
      rst_n = 1'b0;
      #1;
      if (bus.mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", bus.mem_req_valid_o); end
      checks++;
      if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %b want 0", bus.inst_valid_o); end
      checks++;
      if (bus.inst_fault_o !== 1'b0) begin errors++; $display("FAIL rst_inst_fault got %b want 0", bus.inst_fault_o); end
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_o); end
      checks++;
      if (queue_count_o !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", queue_count_o); end
      checks++;
      if (bus.inst_addr_o !== 32'h0) begin errors++; $display("FAIL rst_inst_addr got %h want 0", bus.inst_addr_o); end
      checks++;
      if (bus.inst_data_o !== 32'h0) begin errors++; $display("FAIL rst_inst_data got %h want 0", bus.inst_data_o); end
      checks++;
      if (bus.mem_req_addr_o !== 32'h3000_0000) begin errors++; $display("FAIL rst_pc got %h want 30000000", bus.mem_req_addr_o); end
      checks++;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_stream();
      logic [31:0] exp_req;
      logic [31:0] exp_inst;
      int          ninst;
      do_reset();
      exp_req = 32'h3000_0000;
      exp_inst = 32'h3000_0000;
      ninst = 0;
      fetch_en_i = 1'b1;
      bus.mem_req_ready_i = 1'b1;
      bus.inst_ready_i = 1'b1;
      auto_resp = 1'b1;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
            if (bus.mem_req_addr_o !== exp_req) begin errors++; $display("FAIL stream_req_addr got %h want %h", bus.mem_req_addr_o, exp_req); end
            checks++;
            exp_req += 32'd4;
         end
         if (bus.inst_valid_o && bus.inst_ready_i) begin
            if (bus.inst_addr_o !== exp_inst || bus.inst_data_o !== dat(exp_inst) || bus.inst_fault_o !== 1'b0) begin
               errors++;
               $display("FAIL stream_inst got %h/%h/%b want %h/%h/0", bus.inst_addr_o, bus.inst_data_o, bus.inst_fault_o, exp_inst, dat(exp_inst));
            end
            checks++;
            exp_inst += 32'd4;
            ninst++;
         end
         tick();
      end
      if (ninst < 10) begin errors++; $display("FAIL stream_inst_count got %0d want >=10", ninst); end
      checks++;
   endtask

   task automatic test_full();
      do_reset();
      fetch_en_i = 1'b1;
      bus.mem_req_ready_i = 1'b1;
      auto_resp = 1'b1;
      #1;
      for (int i = 0; i < 12; i++) tick();
      if (nfire !== 4) begin errors++; $display("FAIL full_fires got %0d want 4", nfire); end
      checks++;
      if (bus.mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL full_req_valid got %b want 0", bus.mem_req_valid_o); end
      checks++;
      if (queue_count_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", queue_count_o); end
      checks++;
      if (bus.inst_valid_o !== 1'b1 || bus.inst_addr_o !== 32'h3000_0000 || bus.inst_data_o !== dat(32'h3000_0000)) begin
         errors++;
         $display("FAIL full_head got %b/%h/%h want 1/30000000/%h", bus.inst_valid_o, bus.inst_addr_o, bus.inst_data_o, dat(32'h3000_0000));
      end
      checks++;
      bus.inst_ready_i = 1'b1;
      #1;
      tick();
      bus.inst_ready_i = 1'b0;
      #1;
      if (queue_count_o !== 3'd3) begin errors++; $display("FAIL full_count_after got %0d want 3", queue_count_o); end
      checks++;
      if (bus.mem_req_valid_o !== 1'b1 || bus.mem_req_addr_o !== 32'h3000_0010) begin
         errors++;
         $display("FAIL full_resume got %b/%h want 1/30000010", bus.mem_req_valid_o, bus.mem_req_addr_o);
      end
      checks++;
   endtask

   task automatic test_redirect_drop();
      bit found;
      do_reset();
      fetch_en_i = 1'b1;
      bus.mem_req_ready_i = 1'b1;
      bus.inst_ready_i = 1'b1;
      #1;
      for (int i = 0; i < 10 && nfire < 3; i++) tick();
      bus.mem_req_ready_i = 1'b0;
      #1;
      if (nfire !== 3 || queue_count_o !== 3'd3 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL drop_setup got fires=%0d count=%0d busy=%b want 3/3/1", nfire, queue_count_o, busy_o);
      end
      checks++;
      redirect_valid_i = 1'b1;
      redirect_pc_i = 32'h8000_0000;
      #1;
      if (bus.mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL drop_req_in_redirect got %b want 0", bus.mem_req_valid_o); end
      checks++;
      tick();
      redirect_valid_i = 1'b0;
      bus.mem_req_ready_i = 1'b1;
      #1;
      if (bus.mem_req_valid_o !== 1'b0 || queue_count_o !== 3'd0 || busy_o !== 1'b1 || bus.mem_req_addr_o !== 32'h8000_0000) begin
         errors++;
         $display("FAIL drop_after_redirect got v=%b cnt=%0d busy=%b addr=%h want 0/0/1/80000000", bus.mem_req_valid_o, queue_count_o, busy_o, bus.mem_req_addr_o);
      end
      checks++;
      for (int k = 0; k < 3; k++) begin
         give_resp();
         #1;
         if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL drop_inst_valid[%0d] got %b want 0", k, bus.inst_valid_o); end
         checks++;
         tick();
         bus.mem_resp_valid_i = 1'b0;
         #1;
         if (busy_o !== (k < 2)) begin errors++; $display("FAIL drop_busy[%0d] got %b want %b", k, busy_o, k < 2); end
         checks++;
      end
      auto_resp = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (bus.inst_valid_o) begin
            found = 1'b1;
            if (bus.inst_addr_o !== 32'h8000_0000 || bus.inst_data_o !== dat(32'h8000_0000)) begin
               errors++;
               $display("FAIL drop_first_inst got %h/%h want 80000000/%h", bus.inst_addr_o, bus.inst_data_o, dat(32'h8000_0000));
            end
            checks++;
         end else tick();
      end
      if (!found) begin errors++; $display("FAIL drop_first_inst timeout got none want inst"); checks++; end
   endtask

   task automatic test_fault();
      int ninst;
      bit seen;
      do_reset();
      fault_idx = 2;
      fetch_en_i = 1'b1;
      bus.mem_req_ready_i = 1'b1;
      bus.inst_ready_i = 1'b1;
      auto_resp = 1'b1;
      ninst = 0;
      seen = 1'b0;
      #1;
      for (int i = 0; i < 15; i++) begin
         if (bus.inst_valid_o && bus.inst_ready_i) begin
            ninst++;
            if (bus.inst_fault_o) begin
               seen = 1'b1;
               if (ninst !== 2 || bus.inst_addr_o !== 32'h3000_0004 || bus.inst_data_o !== 32'h0000_0013) begin
                  errors++;
                  $display("FAIL fault_inst got n=%0d addr=%h data=%h want 2/30000004/00000013", ninst, bus.inst_addr_o, bus.inst_data_o);
               end
               checks++;
            end
         end
         tick();
      end
      if (!seen) begin errors++; $display("FAIL fault_seen got 0 want 1"); end
      checks++;
      if (nfire !== 3 || ninst !== 3 || bus.mem_req_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL fault_hold got fires=%0d insts=%0d req=%b want 3/3/0", nfire, ninst, bus.mem_req_valid_o);
      end
      checks++;
      redirect_valid_i = 1'b1;
      redirect_pc_i = 32'h8000_0000;
      #1;
      tick();
      redirect_valid_i = 1'b0;
      #1;
      if (bus.mem_req_valid_o !== 1'b1 || bus.mem_req_addr_o !== 32'h8000_0000) begin
         errors++;
         $display("FAIL fault_resume got %b/%h want 1/80000000", bus.mem_req_valid_o, bus.mem_req_addr_o);
      end
      checks++;
   endtask

   task automatic test_redirect_same_cycle();
      do_reset();
      fetch_en_i = 1'b1;
      bus.mem_req_ready_i = 1'b1;
      bus.inst_ready_i = 1'b1;
      #1;
      for (int i = 0; i < 10 && nfire < 2; i++) tick();
      bus.mem_req_ready_i = 1'b0;
      give_resp();
      redirect_valid_i = 1'b1;
      redirect_pc_i = 32'h8000_0000;
      #1;
      if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL same_inst_valid got %b want 0", bus.inst_valid_o); end
      checks++;
      tick();
      redirect_valid_i = 1'b0;
      bus.mem_resp_valid_i = 1'b0;
      bus.mem_req_ready_i = 1'b1;
      #1;
      if (bus.mem_req_valid_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL same_one_drop got req=%b busy=%b want 0/1", bus.mem_req_valid_o, busy_o);
      end
      checks++;
      give_resp();
      #1;
      tick();
      bus.mem_resp_valid_i = 1'b0;
      #1;
      if (busy_o !== 1'b0 || bus.mem_req_valid_o !== 1'b1 || bus.mem_req_addr_o !== 32'h8000_0000 || queue_count_o !== 3'd0 || bus.inst_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL same_done got busy=%b req=%b addr=%h cnt=%0d iv=%b want 0/1/80000000/0/0", busy_o, bus.mem_req_valid_o, bus.mem_req_addr_o, queue_count_o, bus.inst_valid_o);
      end
      checks++;
   endtask

   task automatic test_latency();
      do_reset();
      fetch_en_i = 1'b1;
      bus.mem_req_ready_i = 1'b1;
      #1;
      for (int i = 0; i < 10 && nfire < 1; i++) tick();
      bus.mem_req_ready_i = 1'b0;
      give_resp();
      #1;
`ifdef IFQ_BYPASS_EN
      if (bus.inst_valid_o !== 1'b1 || bus.inst_data_o !== dat(32'h3000_0000) || bus.inst_addr_o !== 32'h3000_0000) begin
         errors++;
         $display("FAIL lat_bypass got %b/%h/%h want 1/30000000/%h", bus.inst_valid_o, bus.inst_addr_o, bus.inst_data_o, dat(32'h3000_0000));
      end
`else
      if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL lat_no_bypass got %b want 0", bus.inst_valid_o); end
`endif
      checks++;
      tick();
      bus.mem_resp_valid_i = 1'b0;
      #1;
      if (bus.inst_valid_o !== 1'b1 || bus.inst_data_o !== dat(32'h3000_0000) || queue_count_o !== 3'd1) begin
         errors++;
         $display("FAIL lat_next got %b/%h cnt=%0d want 1/%h/1", bus.inst_valid_o, bus.inst_data_o, queue_count_o, dat(32'h3000_0000));
      end
      checks++;
      bus.inst_ready_i = 1'b1;
      #1;
      tick();
      bus.inst_ready_i = 1'b0;
      #1;
      if (bus.inst_valid_o !== 1'b0 || queue_count_o !== 3'd0) begin
         errors++;
         $display("FAIL lat_consumed got %b cnt=%0d want 0/0", bus.inst_valid_o, queue_count_o);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      fetch_en_i = 1'b1;
      bus.mem_req_ready_i = 1'b1;
      #1;
      for (int i = 0; i < 10 && nfire < 2; i++) tick();
      bus.mem_req_ready_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      if (busy_o !== 1'b0 || queue_count_o !== 3'd0) begin
         errors++;
         $display("FAIL mid_async got busy=%b cnt=%0d want 0/0", busy_o, queue_count_o);
      end
      checks++;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      give_resp();
      #1;
      if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL mid_resp_visible got %b want 0", bus.inst_valid_o); end
      checks++;
      tick();
      bus.mem_resp_valid_i = 1'b0;
      #1;
      if (queue_count_o !== 3'd0 || busy_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_ignored got cnt=%0d busy=%b iv=%b want 0/0/0", queue_count_o, busy_o, bus.inst_valid_o);
      end
      checks++;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_stream();
      test_full();
      test_redirect_drop();
      test_fault();
      test_redirect_same_cycle();
      test_latency();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
